// File: rtl/mnist_pkg.sv
// Shared types for the MNIST feature pipeline: pixel type, streamer state
// encoding, and a counter-width helper.
package mnist_pkg;

    localparam int FEATURE_W = 16;

    typedef logic signed [FEATURE_W-1:0] feature_type;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } src_state_type;

    // Index width for a counter covering 0..n-1; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/feature_if.sv
// Single-lane valid/ready feature stream between layers.
interface feature_if;
    import mnist_pkg::*;

    logic              valid;
    logic              ready;
    feature_type [0:0] features;

    modport initiator (output valid, output features, input ready);
    modport target    (input valid, input features, output ready);

endinterface

// File: rtl/raster_counter.sv
// Column/row/image counter walking a stack of images in raster order.
module raster_counter
    import mnist_pkg::*;
#(
    parameter int H = 28,
    parameter int W = 28,
    parameter int N = 1,
    localparam int CW = idx_w(W),
    localparam int RW = idx_w(H),
    localparam int IW = idx_w(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic [IW-1:0] img_o,
    output logic          col_wrap_o,
    output logic          row_wrap_o,
    output logic          last_o
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [IW-1:0] img_q, img_d;
    logic          img_wrap;

    assign col_wrap_o = (col_q == CW'(W - 1));
    assign row_wrap_o = (row_q == RW'(H - 1));
    assign img_wrap   = (img_q == IW'(N - 1));
    assign last_o     = col_wrap_o && row_wrap_o && img_wrap;

    assign col_o = col_q;
    assign row_o = row_q;
    assign img_o = img_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        img_d = img_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
            img_d = '0;
        end else if (inc_i) begin
            if (col_wrap_o) begin
                col_d = '0;
                if (row_wrap_o) begin
                    row_d = '0;
                    img_d = img_wrap ? '0 : img_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
            img_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            img_q <= img_d;
        end
    end

endmodule

// File: rtl/feature_source.sv
// Raster-order image streamer: buffers NUM_IMAGES images and sends them one
// pixel per accepted valid/ready handshake, with optional idle gaps.
module feature_source
    import mnist_pkg::*;
#(
    parameter int    IMAGE_HEIGHT = 28,
    parameter int    IMAGE_WIDTH  = 28,
    parameter int    NUM_IMAGES   = 1,
    parameter int    GAP_CYCLES   = 0,
    parameter bit    load_image   = 1'b0,
    parameter string image_file   = "image.hex",
    localparam int   PIX          = IMAGE_HEIGHT * IMAGE_WIDTH,
    localparam int   DEPTH        = NUM_IMAGES * PIX,
    localparam int   AW           = idx_w(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  feature_type   wr_data,
    output logic          busy,
    output logic          done,
    output logic [31:0]   sent_count,
    feature_if.initiator  features_out
);

    localparam int CW = idx_w(IMAGE_WIDTH);
    localparam int RW = idx_w(IMAGE_HEIGHT);
    localparam int IW = idx_w(NUM_IMAGES);
    localparam int GW = idx_w(GAP_CYCLES);

    src_state_type state_q, state_d;
    logic [31:0]   sent_q, sent_d;
    logic [GW-1:0] gap_q, gap_d;

    feature_type   mem [DEPTH];

    logic [CW-1:0] col_idx;
    logic [RW-1:0] row_idx;
    logic [IW-1:0] img_idx;
    logic          col_wrap, row_wrap, last_pix;
    logic          accept, clr_idx;
    logic [AW-1:0] rd_addr;

    assign accept  = (state_q == S_SEND) && features_out.ready;
    assign clr_idx = ((state_q == S_IDLE) && start) || (state_q == S_DONE);

    raster_counter #(
        .H (IMAGE_HEIGHT),
        .W (IMAGE_WIDTH),
        .N (NUM_IMAGES)
    ) u_idx (
        .clock      (clock),
        .reset      (reset),
        .clr_i      (clr_idx),
        .inc_i      (accept),
        .col_o      (col_idx),
        .row_o      (row_idx),
        .img_o      (img_idx),
        .col_wrap_o (col_wrap),
        .row_wrap_o (row_wrap),
        .last_o     (last_pix)
    );

    // Read is combinational from the registered index so data and valid align.
    assign rd_addr = AW'(int'(img_idx) * PIX + int'(row_idx) * IMAGE_WIDTH + int'(col_idx));

    always_comb begin
        state_d = state_q;
        sent_d  = sent_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEND;
                    sent_d  = '0;
                end
            end
            S_SEND: begin
                if (features_out.ready) begin
                    sent_d = sent_q + 32'd1;
                    if (last_pix) begin
                        state_d = S_DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            sent_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            sent_q  <= sent_d;
            gap_q   <= gap_d;
        end
    end

    // Buffer survives reset; writes only land while idle.
    always_ff @(posedge clock) begin
        if (wr_en && (state_q == S_IDLE)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        features_out.valid    = (state_q == S_SEND);
        features_out.features = '0;
        if (state_q == S_SEND) begin
            features_out.features[0] = mem[rd_addr];
        end
    end

    assign busy       = (state_q == S_SEND) || (state_q == S_GAP);
    assign done       = (state_q == S_DONE);
    assign sent_count = sent_q;

endmodule

// File: tb/tb_feature_source.sv
// Directed bench for feature_source: 2x3 streaming, 2x3 with gaps, 2x28x28.
module tb_feature_source;
    import mnist_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_g, start_b;
    logic        we_a, we_g, we_b;
    logic [10:0] wr_addr;
    feature_type wr_data;
    logic        busy_a, busy_g, busy_b;
    logic        done_a, done_g, done_b;
    logic [31:0] cnt_a, cnt_g, cnt_b;

    int total = 0;
    int bad   = 0;

    feature_if fa ();
    feature_if fg ();
    feature_if fb ();

    feature_source #(.IMAGE_HEIGHT(2), .IMAGE_WIDTH(3), .NUM_IMAGES(1), .GAP_CYCLES(0)) u_a (
        .clock(clk), .reset(rst), .start(start_a), .wr_en(we_a), .wr_addr(wr_addr[2:0]),
        .wr_data(wr_data), .busy(busy_a), .done(done_a), .sent_count(cnt_a), .features_out(fa)
    );

    feature_source #(.IMAGE_HEIGHT(2), .IMAGE_WIDTH(3), .NUM_IMAGES(1), .GAP_CYCLES(2)) u_g (
        .clock(clk), .reset(rst), .start(start_g), .wr_en(we_g), .wr_addr(wr_addr[2:0]),
        .wr_data(wr_data), .busy(busy_g), .done(done_g), .sent_count(cnt_g), .features_out(fg)
    );

    feature_source #(.IMAGE_HEIGHT(28), .IMAGE_WIDTH(28), .NUM_IMAGES(2), .GAP_CYCLES(0)) u_b (
        .clock(clk), .reset(rst), .start(start_b), .wr_en(we_b), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy_b), .done(done_b), .sent_count(cnt_b), .features_out(fb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int p;
        rst = 1'b1;
        start_a = 1'b0; start_g = 1'b0; start_b = 1'b0;
        we_a = 1'b0; we_g = 1'b0; we_b = 1'b0;
        wr_addr = '0; wr_data = '0;
        fa.ready = 1'b0; fg.ready = 1'b0; fb.ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(fa.valid), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_pix", 32'(fa.features[0]), 0);
        chk("rst_valid_b", 32'(fb.valid), 0);
        rst = 1'b0;

        // Load 2x3 buffers with 1..6 and the 2x28x28 buffer with 1..1568
        for (int i = 0; i < 6; i++) begin
            we_a = 1'b1; we_g = 1'b1; wr_addr = 11'(i); wr_data = feature_type'(i + 1);
            tick();
        end
        we_a = 1'b0; we_g = 1'b0;
        for (int i = 0; i < 1568; i++) begin
            we_b = 1'b1; wr_addr = 11'(i); wr_data = feature_type'(i + 1);
            tick();
        end
        we_b = 1'b0;

        // Streaming with ready held high
        fa.ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("a_valid", 32'(fa.valid), 1);
            chk("a_pix", 32'(fa.features[0]), 32'(k + 1));
            tick();
        end
        chk("a_done", 32'(done_a), 1);
        chk("a_done_valid", 32'(fa.valid), 0);
        chk("a_done_pix", 32'(fa.features[0]), 0);
        chk("a_cnt", cnt_a, 6);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("a_done_pulse", 32'(done_a), 0);
        chk("a_cnt_hold", cnt_a, 6);
        tick();
        chk("a_start_in_done_ignored", 32'(busy_a), 0);

        // Write and start in the same idle cycle: first pixel reflects the write
        we_a = 1'b1; wr_addr = 11'd0; wr_data = feature_type'(42); start_a = 1'b1;
        tick();
        we_a = 1'b0; start_a = 1'b0;
        chk("a_wr_start_pix", 32'(fa.features[0]), 42);
        for (int k = 0; k < 6; k++) tick();
        chk("a_wr_start_done", 32'(done_a), 1);
        tick();
        we_a = 1'b1; wr_addr = 11'd0; wr_data = feature_type'(1);
        tick();
        we_a = 1'b0;

        // Ready pattern 1,0,0,1,0,0...
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        p = 0;
        for (int c = 0; c < 40 && p < 6; c++) begin
            fa.ready = (c % 3 == 0);
            chk("t_valid", 32'(fa.valid), 1);
            chk("t_pix", 32'(fa.features[0]), 32'(p + 1));
            chk("t_cnt", cnt_a, 32'(p));
            if (fa.ready) p++;
            tick();
        end
        chk("t_done", 32'(done_a), 1);
        chk("t_cnt_final", cnt_a, 6);
        fa.ready = 1'b1;
        tick();

        // start and wr_en mid-transfer are ignored
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("m_pix", 32'(fa.features[0]), 32'(k + 1));
            if (k == 2) begin
                start_a = 1'b1; we_a = 1'b1; wr_addr = 11'd0; wr_data = feature_type'(77);
            end else begin
                start_a = 1'b0; we_a = 1'b0;
            end
            tick();
        end
        start_a = 1'b0; we_a = 1'b0;
        chk("m_done", 32'(done_a), 1);
        chk("m_cnt", cnt_a, 6);
        tick();

        // Reset after the third accept aborts without done
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("r_cnt3", cnt_a, 3);
        chk("r_pix4", 32'(fa.features[0]), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_valid", 32'(fa.valid), 0);
        chk("r_busy", 32'(busy_a), 0);
        chk("r_cnt", cnt_a, 0);
        chk("r_done", 32'(done_a), 0);
        chk("r_pix", 32'(fa.features[0]), 0);
        tick();
        chk("r_no_done", 32'(done_a), 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("r_restart_pix", 32'(fa.features[0]), 32'(k + 1));
            tick();
        end
        chk("r_restart_done", 32'(done_a), 1);

        // GAP_CYCLES=2: valid 1,0,0 repeating, 6 pixels in 16 cycles
        fg.ready = 1'b1;
        start_g = 1'b1;
        tick();
        start_g = 1'b0;
        for (int c = 0; c < 16; c++) begin
            chk("g_valid", 32'(fg.valid), (c % 3 == 0) ? 1 : 0);
            chk("g_pix", 32'(fg.features[0]), (c % 3 == 0) ? 32'(c / 3 + 1) : 0);
            chk("g_busy", 32'(busy_g), 1);
            tick();
        end
        chk("g_done", 32'(done_g), 1);
        chk("g_cnt", cnt_g, 6);

        // Two 28x28 images back to back
        fb.ready = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 1568; k++) begin
            chk("b_valid", 32'(fb.valid), 1);
            chk("b_pix", 32'(fb.features[0]), 32'(k + 1));
            tick();
        end
        chk("b_done", 32'(done_b), 1);
        chk("b_cnt", cnt_b, 1568);
        tick();
        chk("b_done_pulse", 32'(done_b), 0);
        chk("b_idle", 32'(busy_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
